// File: rtl/seq_addsub_pkg.sv
// ============================================================================
// seq_addsub_pkg : shared constants and state type for the sequential add/sub
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_addsub_pkg;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_addsub_chunk_addsub.sv
// ============================================================================
// chunk_addsub : combinational CHUNK-bit ripple adder / borrow subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module chunk_addsub
   import seq_addsub_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   input  logic             mode,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < CHUNK; i++) begin : g_bit
         logic w_p;
         assign w_p      = x[i] ^ y[i];
         assign s[i]     = w_p ^ w_c[i];
         // w_c carries a carry when adding and a borrow when subtracting
         assign w_c[i+1] = (mode == MODE_ADD)
                         ? ((x[i] & y[i])  | (w_p  & w_c[i]))
                         : ((~x[i] & y[i]) | (~w_p & w_c[i]));
      end
   endgenerate

   assign cout = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/seq_addsub.sv
// ============================================================================
// seq_addsub : multi-cycle add/subtract, CHUNK bits per cycle, LSB chunk first
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] c_LAST = IDXW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] w_d_nxt;
   logic             r_mode;
   logic             r_cy;
   logic [IDXW-1:0]  r_idx;
   logic             r_bout;
   logic             r_ovf;
   logic             r_zero;
   logic [CHUNK-1:0] w_s;
   logic             w_cout;
   logic             w_accept;
   logic             w_last;
   logic             w_ovf;

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_state == RUN) && (r_idx == c_LAST);

   chunk_addsub #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .x    (r_a[r_idx*CHUNK +: CHUNK]),
      .y    (r_b[r_idx*CHUNK +: CHUNK]),
      .cin  (r_cy),
      .mode (r_mode),
      .s    (w_s),
      .cout (w_cout)
   );

   // Result as it will look after this cycle's chunk lands; flags on the last
   // chunk are derived from it so they need no extra cycle.
   always_comb begin
      w_d_nxt                       = r_d;
      w_d_nxt[r_idx*CHUNK +: CHUNK] = w_s;
   end

   always_comb begin
      if (r_mode == MODE_ADD)
         w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_d_nxt[WIDTH-1] != r_a[WIDTH-1]);
      else
         w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_nxt[WIDTH-1] != r_a[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE) & rst_n;
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_d    <= '0;
         r_mode <= MODE_SUB;
         r_cy   <= 1'b0;
         r_idx  <= '0;
         r_bout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_accept) begin
         r_a    <= a;
         r_b    <= b;
         r_mode <= mode;
         r_cy   <= bin;
         r_idx  <= '0;
      end else if (r_state == RUN) begin
         r_d   <= w_d_nxt;
         r_cy  <= w_cout;
         r_idx <= r_idx + 1'b1;
         if (w_last) begin
            r_bout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= (w_d_nxt == '0);
         end
      end
   end

   assign d    = r_d;
   assign bout = r_bout;
   assign ovf  = r_ovf;
   assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub.sv
// ============================================================================
// tb_seq_addsub : directed and random checks of seq_addsub against an
// arithmetic reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_addsub;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;
   logic         zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_addsub #(
      .WIDTH (16),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {bout, ovf, zero, d} from plain wide arithmetic.
   function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mbin, input logic mmode);
      logic [16:0] full;
      logic [15:0] r;
      logic        o;
      if (mmode) full = {1'b0, ma} + {1'b0, mb} + 17'(mbin);
      else       full = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
      r = full[15:0];
      if (mmode) o = (ma[15] == mb[15]) && (r[15] != ma[15]);
      else       o = (ma[15] != mb[15]) && (r[15] != ma[15]);
      return {full[16], o, (r == 16'h0000), r};
   endfunction

   // Called #1 after a rising edge; issues one op and drains it after 'hold' stalled cycles.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         input logic tmode, input int hold, input string tag);
      logic [18:0] exp;
      int          cyc;
      exp = model(ta, tb, tbin, tmode);
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ta; b = tb; bin = tbin; mode = tmode;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); mode = 1'($urandom);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, 32'(cyc), 32'd4);
      check({tag, "_d"},    32'(d),    32'(exp[15:0]));
      check({tag, "_bout"}, 32'(bout), 32'(exp[18]));
      check({tag, "_ovf"},  32'(ovf),  32'(exp[17]));
      check({tag, "_zero"}, 32'(zero), 32'(exp[16]));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
         @(posedge clk); #1;
         check({tag, "_hold"}, {11'd0, out_valid, in_ready, exp[18:16], d},
                               {11'd0, 1'b1, 1'b0, exp});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drain"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_outs", {12'd0, out_valid, in_ready, bout, ovf, zero, d}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_rdy", 32'(in_ready), 32'd1);
      check("post_rst_outs", {13'd0, out_valid, bout, ovf, zero, d}, 32'd0);

      run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 0, "t1_sub");
      run_op(16'h0005, 16'h0005, 1'b1, 1'b0, 0, "t2_borrow");
      run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 0, "t3_subovf");
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, "t3_addovf");
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, "t4_carry");
      run_op(16'hABCD, 16'h1234, 1'b1, 1'b1, 5, "t5_bp");
      run_op(16'h0100, 16'h0001, 1'b0, 1'b0, 0, "t5_next");

      // Abort an operation two RUN cycles in; partial result must vanish at once.
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b0; mode = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_outs", {12'd0, out_valid, in_ready, bout, ovf, zero, d}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("t6_rdy", 32'(in_ready), 32'd1);
      run_op(16'h0010, 16'h0001, 1'b0, 1'b0, 0, "t6_after");

      for (int n = 0; n < 30; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       rb = ra;
            1:       ra = 16'h8000;
            2:       rb = 16'hFFFF;
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
